// File: rtl/dw03_bictr_chk_pkg.sv
// Shared types and constants for the dw03 up/down counter checkers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dw03_bictr_chk_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dw03_bictr_ref_model.sv
// Reference model of the up/down binary counter with dynamic count-to flag.
// Latency: exp_count updates on the same edge as the counter; exp_tercnt is combinational.
// Backpressure: none; it follows the stimulus every cycle.
module dw03_bictr_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             cen,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] count_to,
  output logic [WIDTH-1:0] exp_count,
  output logic             exp_tercnt
);

  // Count register: reset beats preset (load is active-low), preset beats counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_count <= '0;
    end else if (!load) begin
      exp_count <= data;
    end else if (cen) begin
      exp_count <= up_dn ? exp_count + WIDTH'(1) : exp_count - WIDTH'(1);
    end
  end

  // Terminal count follows count_to within the same cycle.
  assign exp_tercnt = (exp_count == count_to);

endmodule

// File: rtl/dw03_bictr_dcnto_chk.sv
// Checker comparing a dw03 up/down counter against its reference model every clock.
// Latency: 1 cycle from sampled DUT outputs to err/err_sticky/counters.
// Backpressure: none; purely observes, halts comparing after MAX_ERR mismatches.
module dw03_bictr_dcnto_chk
  import dw03_bictr_chk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_ERR = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             cen,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] count_to,
  input  logic [WIDTH-1:0] dut_count,
  input  logic             dut_tercnt,
  input  logic             chk_en,
  output logic             err,
  output logic             err_sticky,
  output logic [15:0]      err_cnt,
  output logic [15:0]      chk_cnt,
  output logic [15:0]      tc_cnt,
  output logic [WIDTH-1:0] exp_count,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] MAX_ERR_V = CNT_W'(MAX_ERR);

  state_t           state_q;
  state_t           state_d;
  logic             exp_tercnt;
  logic             mismatch;
  logic             do_cmp;
  logic [CNT_W-1:0] err_cnt_inc;

  dw03_bictr_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .cen        (cen),
    .up_dn      (up_dn),
    .data       (data),
    .count_to   (count_to),
    .exp_count  (exp_count),
    .exp_tercnt (exp_tercnt)
  );

  // Case inequality so X/Z on the DUT outputs is reported rather than masked.
  assign mismatch    = (dut_count !== exp_count) || (dut_tercnt !== exp_tercnt);
  assign err_cnt_inc = sat_inc(err_cnt);
  assign state       = state_q;

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and compare qualifier; IDLE spends one alignment cycle before comparing.
  always_comb begin
    state_d = state_q;
    do_cmp  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        do_cmp = chk_en;
        if (do_cmp && mismatch && (err_cnt_inc >= MAX_ERR_V)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Error pulse, sticky flag and saturating statistics, updated only on compared cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      chk_cnt    <= '0;
      tc_cnt     <= '0;
    end else begin
      err <= do_cmp && mismatch;
      if (do_cmp) begin
        chk_cnt <= sat_inc(chk_cnt);
        if (exp_tercnt) begin
          tc_cnt <= sat_inc(tc_cnt);
        end
        if (mismatch) begin
          err_sticky <= 1'b1;
          err_cnt    <= err_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_dw03_bictr_dcnto_chk.sv
// Directed bench for dw03_bictr_dcnto_chk with an abstract reference of the checker.
// Latency: stimulus driven on falling edges, outputs compared on falling edges.
// Backpressure: n/a.
module tb_dw03_bictr_dcnto_chk;

  localparam int WIDTH   = 4;
  localparam int MAX_ERR = 8;
  localparam int MODV    = 1 << WIDTH;
  localparam int SAT     = 65535;

  logic             clk = 1'b0;
  logic             reset, load, cen, up_dn, chk_en;
  logic [WIDTH-1:0] data, count_to, dut_count;
  logic             dut_tercnt;
  logic             err, err_sticky;
  logic [15:0]      err_cnt, chk_cnt, tc_cnt;
  logic [WIDTH-1:0] exp_count;
  logic [1:0]       state;

  int n_chk = 0;
  int n_err = 0;

  // Abstract expectation: phase 0 = not yet aligned, 1 = comparing, 2 = halted.
  int m_count = 0, m_phase = 0, m_err = 0, m_sticky = 0;
  int m_err_cnt = 0, m_chk_cnt = 0, m_tc_cnt = 0;
  bit m_tc, m_bad;

  // Fault injection for the emulated DUT.
  logic             corrupt  = 1'b0;
  logic             force_tc = 1'b0;
  logic [WIDTH-1:0] cval     = '0;

  dw03_bictr_dcnto_chk #(
    .WIDTH   (WIDTH),
    .MAX_ERR (MAX_ERR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .cen        (cen),
    .up_dn      (up_dn),
    .data       (data),
    .count_to   (count_to),
    .dut_count  (dut_count),
    .dut_tercnt (dut_tercnt),
    .chk_en     (chk_en),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .chk_cnt    (chk_cnt),
    .tc_cnt     (tc_cnt),
    .exp_count  (exp_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected checker behaviour per rising edge, from the operational rules.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_err = 0; m_sticky = 0;
      m_err_cnt = 0; m_chk_cnt = 0; m_tc_cnt = 0; m_count = 0;
    end else begin
      m_err = 0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1 && chk_en) begin
        m_tc  = (m_count == int'(count_to));
        m_bad = (dut_count !== WIDTH'(m_count)) || (dut_tercnt !== m_tc);
        if (m_chk_cnt < SAT) m_chk_cnt++;
        if (m_tc && m_tc_cnt < SAT) m_tc_cnt++;
        if (m_bad) begin
          m_err = 1;
          m_sticky = 1;
          if (m_err_cnt < SAT) m_err_cnt++;
          if (m_err_cnt >= MAX_ERR) m_phase = 2;
        end
      end
      if (!load) m_count = int'(data);
      else if (cen) m_count = up_dn ? (m_count + 1) % MODV : (m_count + MODV - 1) % MODV;
    end
  end

  // Every-cycle comparison of all checker outputs against the expectation.
  always @(negedge clk) begin
    check("err",        int'(err),        m_err);
    check("err_sticky", int'(err_sticky), m_sticky);
    check("err_cnt",    int'(err_cnt),    m_err_cnt);
    check("chk_cnt",    int'(chk_cnt),    m_chk_cnt);
    check("tc_cnt",     int'(tc_cnt),     m_tc_cnt);
    check("exp_count",  int'(exp_count),  m_count);
    check("state",      int'(state),      m_phase);
  end

  // Emulated DUT outputs for the coming edge, then advance one clock.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      dut_count  = corrupt ? cval : WIDTH'(m_count);
      dut_tercnt = force_tc ? 1'b1 : (m_count == int'(count_to));
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b1; cen = 1'b0; up_dn = 1'b1; chk_en = 1'b1;
    data = '0; count_to = 4'd15;

    // Reset, then preset to 9 with a matching DUT.
    tick(2);
    check("lit_rst_state", int'(state), 0);
    check("lit_rst_exp", int'(exp_count), 0);
    check("lit_rst_errcnt", int'(err_cnt), 0);
    check("lit_rst_chkcnt", int'(chk_cnt), 0);
    reset = 1'b0; load = 1'b0; data = 4'd9;
    tick(1);
    check("lit_load_exp", int'(exp_count), 9);
    check("lit_align_state", int'(state), 1);
    check("lit_align_chkcnt", int'(chk_cnt), 0);
    load = 1'b1;
    tick(3);
    check("lit_hold_chkcnt", int'(chk_cnt), 3);
    check("lit_hold_errcnt", int'(err_cnt), 0);

    // Count up from 0 for 20 cycles with count_to = 8.
    load = 1'b0; data = 4'd0; count_to = 4'd8;
    tick(1);
    load = 1'b1; cen = 1'b1; up_dn = 1'b1;
    tick(20);
    check("lit_up_tccnt", int'(tc_cnt), 1);
    check("lit_up_exp", int'(exp_count), 4);
    check("lit_up_errcnt", int'(err_cnt), 0);
    check("lit_up_chkcnt", int'(chk_cnt), 24);

    // Load wins over cen, then count down through the wrap.
    load = 1'b0; data = 4'd0;
    tick(1);
    check("lit_loadwin_exp", int'(exp_count), 0);
    load = 1'b1; up_dn = 1'b0;
    tick(1);
    check("lit_down_wrap", int'(exp_count), 15);
    tick(1);
    check("lit_down_exp", int'(exp_count), 14);
    cen = 1'b0; force_tc = 1'b1;
    tick(1);
    check("lit_tc_err", int'(err), 1);
    check("lit_tc_sticky", int'(err_sticky), 1);
    check("lit_tc_errcnt", int'(err_cnt), 1);
    force_tc = 1'b0;
    tick(1);
    check("lit_pulse_end", int'(err), 0);
    check("lit_sticky_hold", int'(err_sticky), 1);
    check("lit_c_chkcnt", int'(chk_cnt), 29);

    // Comparison disabled while the DUT is corrupted.
    chk_en = 1'b0; corrupt = 1'b1; cval = 4'd5; cen = 1'b1; up_dn = 1'b1;
    tick(5);
    check("lit_dis_errcnt", int'(err_cnt), 1);
    check("lit_dis_chkcnt", int'(chk_cnt), 29);
    check("lit_dis_exp", int'(exp_count), 3);
    check("lit_dis_err", int'(err), 0);

    // Stuck DUT count until MAX_ERR halts the checker.
    chk_en = 1'b1; cval = 4'd15;
    tick(7);
    check("lit_halt_err", int'(err), 1);
    check("lit_halt_errcnt", int'(err_cnt), 8);
    check("lit_halt_state", int'(state), 2);
    check("lit_halt_chkcnt", int'(chk_cnt), 36);
    check("lit_halt_tccnt", int'(tc_cnt), 2);
    check("lit_halt_exp", int'(exp_count), 10);
    tick(3);
    check("lit_frz_err", int'(err), 0);
    check("lit_frz_errcnt", int'(err_cnt), 8);
    check("lit_frz_chkcnt", int'(chk_cnt), 36);
    check("lit_frz_state", int'(state), 2);
    check("lit_frz_exp", int'(exp_count), 13);
    check("lit_frz_sticky", int'(err_sticky), 1);

    // Reset out of HALT, realign, resume.
    reset = 1'b1;
    tick(1);
    check("lit_rst2_state", int'(state), 0);
    check("lit_rst2_exp", int'(exp_count), 0);
    check("lit_rst2_sticky", int'(err_sticky), 0);
    check("lit_rst2_errcnt", int'(err_cnt), 0);
    check("lit_rst2_tccnt", int'(tc_cnt), 0);
    reset = 1'b0; corrupt = 1'b0;
    tick(1);
    check("lit_realign_state", int'(state), 1);
    check("lit_realign_chkcnt", int'(chk_cnt), 0);
    check("lit_realign_exp", int'(exp_count), 1);
    tick(1);
    check("lit_resume_chkcnt", int'(chk_cnt), 1);
    check("lit_resume_err", int'(err), 0);
    check("lit_resume_exp", int'(exp_count), 2);

    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dw03_bictr_dcnto_chk.md
# dw03_bictr_dcnto_chk

Cycle-accurate checker for the up/down binary counter with dynamic count-to flag. It sits on the other side of the DUT from the stimulus generator. It observes the same stimulus (load, cen, up_dn, data, count_to) and the DUT outputs (count, tercnt), and runs an internal reference model of the counter. It compares the model to the DUT every clock and reports mismatches through pulse, sticky and counter outputs.

## Interface
- WIDTH, 4: counter width in bits; must match the DUT.
- MAX_ERR, 8: error count at which checking halts; range 1..65535.
- clk  input  1  clock, shared with the DUT and the stimulus generator.
- reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- load  input  1  DUT preset command, active-low.
- cen  input  1  DUT count enable, active-high.
- up_dn  input  1  count direction: 1 = up, 0 = down.
- data  input  WIDTH  preset value.
- count_to  input  WIDTH  terminal-count compare value.
- dut_count  input  WIDTH  DUT count output.
- dut_tercnt  input  1  DUT terminal-count flag.
- chk_en  input  1  comparison enable; the model tracks the DUT regardless of this input.
- err  output  1  one-cycle pulse on a detected mismatch.
- err_sticky  output  1  set on the first mismatch; cleared only by reset.
- err_cnt  output  16  number of mismatching cycles, saturating.
- chk_cnt  output  16  number of compared cycles, saturating.
- tc_cnt  output  16  number of cycles with expected tercnt = 1, saturating.
- exp_count  output  WIDTH  reference model count.
- state  output  2  checker FSM state.

## Operation
- Reference model, next-value priority: reset > load==0 > cen==1 > hold.
  - reset → 0.
  - load==0 → data.
  - cen with up_dn=1 → +1, mod 2^WIDTH. 2^WIDTH-1 wraps to 0.
  - cen with up_dn=0 → −1, mod 2^WIDTH. 0 wraps to 2^WIDTH-1.
- Expected tercnt = (exp_count == count_to), combinational on the current count_to.
- A mismatch is (dut_count != exp_count) or (dut_tercnt != expected tercnt).
  - X or Z on dut_count or dut_tercnt counts as a mismatch (case-inequality semantics).
  - X on data or count_to is ignored while load==1 and no compare is in progress.
- FSM states:
  - IDLE (0): entered on reset; no compare. Moves to CHECK on the first cycle with reset==0, which is the alignment cycle.
  - CHECK (1): each cycle with chk_en=1: chk_cnt+1, tc_cnt+1 if expected tercnt = 1, and on mismatch err=1 and err_cnt+1. Moves to HALT when err_cnt reaches MAX_ERR.
  - HALT (2): compares, counters and err are frozen; err_sticky stays 1; the model keeps tracking. Leaves only on reset.
  - State 3 is unused; if ever reached it returns to IDLE.
- All 16-bit counters saturate at 16'hFFFF.
- chk_en=0 in CHECK: no compare, no counter update, err=0.

## Timing
- Reset values: err=0, err_sticky=0, err_cnt=0, chk_cnt=0, tc_cnt=0, exp_count=0, state=IDLE.
- The compare at rising edge N uses the values sampled at edge N, i.e. DUT outputs produced by edge N-1. err, err_sticky and the counters update at edge N and are visible for cycle N to N+1. Latency is 1 cycle.
- exp_count updates on the same edge as the DUT count.
- Simultaneous mismatch and MAX_ERR reach: err pulses and err_cnt = MAX_ERR, then state=HALT on that same edge.
- Reset asserted mid-operation: all outputs return to reset values at the next edge. The compare on that edge is suppressed.
- load==0 and cen==1 together: load wins, same as the DUT.
- A count_to change applies to expected tercnt combinationally, in the same cycle.

## Structure
- Package dw03_bictr_chk_pkg:
  - state enum: ST_IDLE, ST_CHECK, ST_HALT.
  - CNT_W = 16.
  - CNT_MAX = 16'hFFFF.
- Sub-module dw03_bictr_ref_model: parameter WIDTH; inputs clk, reset, load, cen, up_dn, data, count_to; outputs exp_count, exp_tercnt. Reused by later checkers.
- The top level holds the FSM, the compare logic and the saturating counters.

## Test plan
All scenarios use WIDTH=4.
- Reset 2 cycles, then load=0 with data=4'd9 while the DUT matches → exp_count=9 one cycle later, err never 1, chk_cnt increments each cycle.
- Count up from 0 with count_to=8 for 20 cycles → exp_count wraps 15→0, tc_cnt=1 at count 8, err_cnt=0.
- Count down from 0 → exp_count=15, then 14. Force dut_tercnt=1 when count != count_to → err pulse 1 cycle, err_sticky=1, err_cnt=1.
- Force a stuck dut_count for 10 cycles with MAX_ERR=8 → err_cnt stops at 8, state=HALT, chk_cnt frozen.
- chk_en=0 for 5 cycles with a corrupted DUT → err_cnt and chk_cnt unchanged, exp_count keeps tracking.
- Assert reset in HALT → all outputs return to reset values, state=IDLE, then CHECK on the next cycle.
